// File: rtl/aes_inv_add_round_key_stage.sv
// AddRoundKey stage of the AES-128 inverse cipher: on-chip key schedule store,
// round-key XOR at accept time, and an output register backed by a one-entry skid buffer.
module aes_inv_add_round_key_stage #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_wr_en,
  input  logic [5:0]   key_wr_addr,
  input  logic [31:0]  key_wr_data,
  input  logic         key_clear,
  output logic         key_valid,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [3:0]   in_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [3:0]   out_round,
  output logic         out_mix_en,
  output logic         out_last,
  output logic         err
);

  localparam int         DEPTH     = 4 * (NUM_ROUNDS + 1);
  localparam logic [5:0] DEPTH_W   = 6'(DEPTH);
  localparam logic [3:0] MAX_ROUND = 4'(NUM_ROUNDS);

  logic [31:0]      r_key_mem [DEPTH];
  logic [DEPTH-1:0] r_mask;
  logic             r_key_valid;
  logic             r_in_ready;
  logic             r_err;

  logic             r_out_valid;
  logic [127:0]     r_out_state;
  logic [3:0]       r_out_round;
  logic             r_out_mix_en;
  logic             r_out_last;

  logic             r_skid_valid;
  logic [127:0]     r_skid_state;
  logic [3:0]       r_skid_round;
  logic             r_skid_mix_en;
  logic             r_skid_last;

  logic             w_addr_ok;
  logic             w_key_wr_ok;
  logic             w_accept;
  logic             w_out_free;
  logic             w_round_ok;
  logic [127:0]     w_round_key;
  logic [127:0]     w_new_state;
  logic             w_new_mix_en;
  logic             w_new_last;
  logic             w_key_valid_nxt;
  logic             w_skid_valid_nxt;

  assign w_addr_ok    = key_wr_addr < DEPTH_W;
  assign w_key_wr_ok  = key_wr_en & ~key_clear & w_addr_ok;
  assign w_accept     = in_valid & r_in_ready;
  assign w_out_free   = ~r_out_valid | out_ready;
  assign w_round_ok   = in_round <= MAX_ROUND;

  // Out-of-range rounds select an all-zero key so the state passes through untouched.
  always_comb begin
    w_round_key = '0;
    if (w_round_ok) begin
      for (int c = 0; c < 4; c++) begin
        w_round_key[127 - 32*c -: 32] = r_key_mem[{in_round, 2'b00} + 6'(c)];
      end
    end
  end

  assign w_new_state  = in_state ^ w_round_key;
  assign w_new_mix_en = w_round_ok && (in_round != 4'd0) && (in_round != MAX_ROUND);
  assign w_new_last   = in_round == 4'd0;

  assign w_key_valid_nxt  = ~key_clear & (&r_mask);
  assign w_skid_valid_nxt = r_skid_valid ? ~w_out_free : (w_accept & ~w_out_free);

  always_ff @(posedge clk) begin
    if (w_key_wr_ok) begin
      r_key_mem[key_wr_addr] <= key_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mask        <= '0;
      r_key_valid   <= 1'b0;
      r_in_ready    <= 1'b0;
      r_err         <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_state   <= '0;
      r_out_round   <= '0;
      r_out_mix_en  <= 1'b0;
      r_out_last    <= 1'b0;
      r_skid_valid  <= 1'b0;
      r_skid_state  <= '0;
      r_skid_round  <= '0;
      r_skid_mix_en <= 1'b0;
      r_skid_last   <= 1'b0;
    end else begin
      if (key_clear) begin
        r_mask <= '0;
      end else if (w_key_wr_ok) begin
        r_mask[key_wr_addr] <= 1'b1;
      end

      r_key_valid <= w_key_valid_nxt;

      if (key_clear) begin
        r_err <= 1'b0;
      end else if ((key_wr_en & ~w_addr_ok) | (w_accept & ~w_round_ok)) begin
        r_err <= 1'b1;
      end

      // Skid contents always leave before anything new; in_ready guarantees the skid is empty on accept.
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_out_valid  <= 1'b1;
          r_out_state  <= r_skid_state;
          r_out_round  <= r_skid_round;
          r_out_mix_en <= r_skid_mix_en;
          r_out_last   <= r_skid_last;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_out_valid  <= 1'b1;
          r_out_state  <= w_new_state;
          r_out_round  <= in_round;
          r_out_mix_en <= w_new_mix_en;
          r_out_last   <= w_new_last;
        end else begin
          r_out_valid  <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid_valid  <= 1'b1;
        r_skid_state  <= w_new_state;
        r_skid_round  <= in_round;
        r_skid_mix_en <= w_new_mix_en;
        r_skid_last   <= w_new_last;
      end

      r_in_ready <= w_key_valid_nxt & ~w_skid_valid_nxt;
    end
  end

  assign key_valid  = r_key_valid;
  assign in_ready   = r_in_ready;
  assign err        = r_err;
  assign out_valid  = r_out_valid;
  assign out_state  = r_out_state;
  assign out_round  = r_out_round;
  assign out_mix_en = r_out_mix_en;
  assign out_last   = r_out_last;

endmodule
